// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life frame streamer.
// The FSM state type and the default grid edge length live here.
package life_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic {
    StIdle,
    StStream
  } state_e;

endpackage

// File: rtl/life_frame_streamer_if.sv
// Bundle of generation-input and row-output signals of the frame streamer.
// The slave modport is the streamer side; the master modport is the producer/consumer side.
interface life_frame_streamer_if
  import life_pkg::*;
#(
  parameter int unsigned N = DefaultN
);

  logic [N*N-1:0]           cells;
  logic                     gen_valid;
  logic                     row_ready;
  logic                     row_valid;
  logic [N-1:0]             row_data;
  logic [$clog2(N)-1:0]     row_idx;
  logic                     row_last;
  logic [$clog2(N*N+1)-1:0] pop_count;
  logic                     busy;
  logic                     drop_pulse;
  logic [7:0]               drop_count;

  modport master (
    output cells, gen_valid, row_ready,
    input  row_valid, row_data, row_idx, row_last, pop_count, busy, drop_pulse, drop_count
  );

  modport slave (
    input  cells, gen_valid, row_ready,
    output row_valid, row_data, row_idx, row_last, pop_count, busy, drop_pulse, drop_count
  );

endinterface

// File: rtl/life_popcount.sv
// Purely combinational population count of a W-bit vector.
module life_popcount #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0]             in_i,
  output logic [$clog2(W+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CntW'(in_i[i]);
    end
  end

endmodule

// File: rtl/life_frame_streamer.sv
// Captures a Game of Life generation into a snapshot and streams it out row by row
// with a valid/ready handshake, dropping generations that arrive mid-frame.
module life_frame_streamer
  import life_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input logic                 clk,
  input logic                 rst,
  life_frame_streamer_if.slave bus
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned PopW = $clog2(N * N + 1);
  localparam logic [IdxW-1:0] LastRow = IdxW'(N - 1);

  state_e            state_q, state_d;
  logic [N*N-1:0]    snap_q, snap_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [PopW-1:0]   pop_q, pop_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [PopW-1:0]   cells_pop;
  logic              streaming;
  logic              handshake;
  logic              at_last;
  logic [N-1:0]      rows [N];

  life_popcount #(
    .W (N * N)
  ) u_popcount (
    .in_i    (bus.cells),
    .count_o (cells_pop)
  );

  assign streaming = (state_q == StStream);
  assign handshake = streaming && bus.row_ready;
  assign at_last   = (ptr_q == LastRow);

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    ptr_d        = ptr_q;
    pop_d        = pop_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.gen_valid) begin
          snap_d  = bus.cells;
          pop_d   = cells_pop;
          ptr_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (handshake && at_last) begin
          // A generation arriving on the final handshake chains straight into a new frame.
          if (bus.gen_valid) begin
            snap_d  = bus.cells;
            pop_d   = cells_pop;
            ptr_d   = '0;
          end else begin
            ptr_d   = '0;
            state_d = StIdle;
          end
        end else begin
          if (handshake) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (bus.gen_valid) begin
            drop_pulse_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      ptr_q        <= '0;
      pop_q        <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      ptr_q        <= ptr_d;
      pop_q        <= pop_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Row 0 occupies the most significant N bits of the snapshot.
  for (genvar r = 0; r < N; r++) begin : g_rows
    assign rows[r] = snap_q[(N-1-r)*N +: N];
  end

  assign bus.row_valid  = streaming;
  assign bus.busy       = streaming;
  assign bus.row_data   = rows[ptr_q];
  assign bus.row_idx    = ptr_q;
  assign bus.row_last   = streaming && at_last;
  assign bus.pop_count  = pop_q;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_life_frame_streamer.sv
// Self-checking bench for life_frame_streamer: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_life_frame_streamer;
  import life_pkg::*;

  localparam int unsigned N = 8;
  localparam logic [63:0] Glider = 64'h4020E00000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  life_frame_streamer_if #(.N(N)) bus ();

  life_frame_streamer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] row_of(input logic [63:0] f, input int r);
    return f[(7-r)*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [63:0] c);
    bus.cells     = c;
    bus.gen_valid = 1'b1;
    step();
    bus.gen_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.gen_valid = 1'b0;
    bus.row_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.row_valid !== 1'b0 || bus.row_data !== 8'h00 || bus.row_idx !== 3'd0 ||
        bus.row_last !== 1'b0 || bus.pop_count !== 7'd0 || bus.busy !== 1'b0 ||
        bus.drop_pulse !== 1'b0 || bus.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h idx=%0d last=%b pop=%0d busy=%b dp=%b dc=%0d, want all 0",
               bus.row_valid, bus.row_data, bus.row_idx, bus.row_last, bus.pop_count,
               bus.busy, bus.drop_pulse, bus.drop_count);
    end
  endtask

  task automatic test_glider();
    do_reset();
    bus.row_ready = 1'b1;
    capture(Glider);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (bus.row_valid !== 1'b1 || bus.row_data !== row_of(Glider, r) ||
          bus.row_idx !== 3'(r) || bus.row_last !== (r == 7) || bus.pop_count !== 7'd5 ||
          bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL glider row %0d: valid=%b data=%h idx=%0d last=%b pop=%0d, want 1 %h %0d %b 5",
                 r, bus.row_valid, bus.row_data, bus.row_idx, bus.row_last, bus.pop_count,
                 row_of(Glider, r), r, (r == 7));
      end
      step();
    end
    checks++;
    if (bus.row_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL glider end: valid=%b busy=%b, want 0 0", bus.row_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.row_ready = 1'b1;
    capture(Glider);
    for (int r = 0; r < 8; r++) begin
      if (r == 2) begin
        bus.row_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          checks++;
          if (bus.row_valid !== 1'b1 || bus.row_data !== 8'hE0 || bus.row_idx !== 3'd2 ||
              bus.row_last !== 1'b0) begin
            errors++;
            $display("FAIL hold cycle %0d: valid=%b data=%h idx=%0d last=%b, want 1 e0 2 0",
                     h, bus.row_valid, bus.row_data, bus.row_idx, bus.row_last);
          end
          step();
        end
        bus.row_ready = 1'b1;
      end
      checks++;
      if (bus.row_valid !== 1'b1 || bus.row_data !== row_of(Glider, r) ||
          bus.row_idx !== 3'(r)) begin
        errors++;
        $display("FAIL backpressure row %0d: valid=%b data=%h idx=%0d, want 1 %h %0d",
                 r, bus.row_valid, bus.row_data, bus.row_idx, row_of(Glider, r), r);
      end
      step();
    end
    checks++;
    if (bus.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure end: valid=%b, want 0", bus.row_valid);
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.row_ready = 1'b1;
    capture(Glider);
    repeat (3) step();
    bus.cells     = '1;
    bus.gen_valid = 1'b1;
    step();
    bus.gen_valid = 1'b0;
    checks++;
    if (bus.drop_pulse !== 1'b1 || bus.drop_count !== 8'd1 || bus.pop_count !== 7'd5 ||
        bus.row_data !== 8'h00 || bus.row_idx !== 3'd4) begin
      errors++;
      $display("FAIL drop: dp=%b dc=%0d pop=%0d data=%h idx=%0d, want 1 1 5 00 4",
               bus.drop_pulse, bus.drop_count, bus.pop_count, bus.row_data, bus.row_idx);
    end
    for (int r = 5; r < 8; r++) begin
      step();
      checks++;
      if (bus.drop_pulse !== 1'b0 || bus.row_data !== row_of(Glider, r) ||
          bus.row_idx !== 3'(r) || bus.pop_count !== 7'd5 || bus.drop_count !== 8'd1) begin
        errors++;
        $display("FAIL drop tail row %0d: dp=%b data=%h idx=%0d pop=%0d dc=%0d, want 0 %h %0d 5 1",
                 r, bus.drop_pulse, bus.row_data, bus.row_idx, bus.pop_count, bus.drop_count,
                 row_of(Glider, r), r);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] dc_before;
    do_reset();
    bus.row_ready = 1'b1;
    capture(Glider);
    repeat (7) step();
    dc_before     = bus.drop_count;
    bus.cells     = '1;
    bus.gen_valid = 1'b1;
    step();
    bus.gen_valid = 1'b0;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.row_idx !== 3'd0 || bus.row_data !== 8'hFF ||
        bus.pop_count !== 7'd64 || bus.drop_count !== dc_before || bus.drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: valid=%b idx=%0d data=%h pop=%0d dc=%0d dp=%b, want 1 0 ff 64 %0d 0",
               bus.row_valid, bus.row_idx, bus.row_data, bus.pop_count, bus.drop_count,
               bus.drop_pulse, dc_before);
    end
    repeat (8) step();
    checks++;
    if (bus.row_valid !== 1'b0 || bus.pop_count !== 7'd64) begin
      errors++;
      $display("FAIL back_to_back end: valid=%b pop=%0d, want 0 64", bus.row_valid, bus.pop_count);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    bus.row_ready = 1'b1;
    capture(Glider);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    test_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.row_valid !== 1'b0) begin
        errors++;
        $display("FAIL post-reset idle cycle %0d: valid=%b, want 0", i, bus.row_valid);
      end
      step();
    end
    capture(Glider);
    checks++;
    if (bus.row_valid !== 1'b1 || bus.row_idx !== 3'd0 || bus.row_data !== 8'h40) begin
      errors++;
      $display("FAIL post-reset frame: valid=%b idx=%0d data=%h, want 1 0 40",
               bus.row_valid, bus.row_idx, bus.row_data);
    end
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    capture('1);
    checks++;
    if (bus.row_valid !== 1'b1 || bus.row_idx !== 3'd0 || bus.row_data !== 8'hFF ||
        bus.pop_count !== 7'd64) begin
      errors++;
      $display("FAIL gen after release: valid=%b idx=%0d data=%h pop=%0d, want 1 0 ff 64",
               bus.row_valid, bus.row_idx, bus.row_data, bus.pop_count);
    end
    repeat (8) step();
  endtask

  task automatic test_saturation();
    do_reset();
    capture(Glider);
    bus.cells     = '1;
    bus.gen_valid = 1'b1;
    repeat (300) step();
    bus.gen_valid = 1'b0;
    step();
    checks++;
    if (bus.drop_count !== 8'd255 || bus.row_idx !== 3'd0 || bus.row_data !== 8'h40 ||
        bus.pop_count !== 7'd5 || bus.drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL saturation: dc=%0d idx=%0d data=%h pop=%0d dp=%b, want 255 0 40 5 0",
               bus.drop_count, bus.row_idx, bus.row_data, bus.pop_count, bus.drop_pulse);
    end
    bus.row_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_random();
    logic [63:0] mframe;
    int          mptr;
    int          mpop;
    int          mdrops;
    bit          mbusy;
    bit          mpulse;
    bit          gv, rdy, hs, fin;
    logic [63:0] c;
    int          bad;
    do_reset();
    mframe = '0;
    mptr   = 0;
    mpop   = 0;
    mdrops = 0;
    mbusy  = 0;
    bad    = 0;
    for (int i = 0; i < 1500; i++) begin
      gv  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      c   = {$urandom, $urandom};
      bus.cells     = c;
      bus.gen_valid = gv;
      bus.row_ready = rdy;
      hs     = mbusy && rdy;
      fin    = hs && (mptr == 7);
      mpulse = 0;
      if (gv && (!mbusy || fin)) begin
        mframe = c;
        mpop   = $countones(c);
        mptr   = 0;
        mbusy  = 1;
      end else if (mbusy) begin
        if (gv) begin
          mpulse = 1;
          if (mdrops < 255) mdrops++;
        end
        if (fin) mbusy = 0;
        else if (hs) mptr++;
      end
      step();
      checks++;
      if (bus.row_valid !== mbusy || bus.pop_count !== 7'(mpop) ||
          bus.drop_pulse !== mpulse || bus.drop_count !== 8'(mdrops) ||
          (mbusy && (bus.row_data !== row_of(mframe, mptr) || bus.row_idx !== 3'(mptr) ||
                     bus.row_last !== (mptr == 7)))) begin
        errors++;
        bad++;
        if (bad <= 10) begin
          $display("FAIL random cycle %0d: valid=%b data=%h idx=%0d pop=%0d dp=%b dc=%0d, want %b %h %0d %0d %b %0d",
                   i, bus.row_valid, bus.row_data, bus.row_idx, bus.pop_count, bus.drop_pulse,
                   bus.drop_count, mbusy, row_of(mframe, mptr), mptr, mpop, mpulse, mdrops);
        end
      end
    end
    bus.gen_valid = 1'b0;
  endtask

  initial begin
    bus.cells     = '0;
    bus.gen_valid = 1'b0;
    bus.row_ready = 1'b0;
    rst           = 1'b1;
    #1;
    test_reset();
    step();
    step();
    test_reset();
    rst = 1'b0;
    test_glider();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_frame_streamer.md
LIFE_FRAME_STREAMER -- requirements
Module: life_frame_streamer

Interface
REQ-001 Parameter: N, default 8, grid edge length (N x N cells), N >= 2.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: cells  in  N*N  current generation from GameOfLife; bits [N*N-1 : N*(N-1)] = row 0 (top), MSB of each row = column 0.
REQ-005 Port: gen_valid  in  1  one-cycle strobe: cells holds a new, stable generation this cycle.
REQ-006 Port: row_ready  in  1  downstream consumer accepts row this cycle.
REQ-007 Port: row_valid  out  1  row_data/row_idx/row_last are valid.
REQ-008 Port: row_data  out  N  one grid row, same bit order as cells.
REQ-009 Port: row_idx  out  $clog2(N)  index of row on row_data, 0 = top.
REQ-010 Port: row_last  out  1  high with row_valid on row N-1.
REQ-011 Port: pop_count  out  $clog2(N*N+1)  live-cell count of the most recently captured frame.
REQ-012 Port: busy  out  1  high while a frame is being streamed.
REQ-013 Port: drop_pulse  out  1  one-cycle pulse when a gen_valid is discarded.
REQ-014 Port: drop_count  out  8  saturating count of discarded generations.

Function
REQ-015 Two states SHALL exist: IDLE and STREAM.
REQ-016 In IDLE, gen_valid SHALL capture cells into an internal N*N snapshot, set pop_count to the popcount of cells, clear the row pointer, and move to STREAM.
REQ-017 row_valid SHALL be high from the cycle after capture (latency 1) until the row N-1 handshake completes; row_valid SHALL equal busy.
REQ-018 A handshake SHALL occur when row_valid and row_ready are both high; on it the row pointer advances by 1.
REQ-019 While row_valid is high and row_ready low, row_data, row_idx, row_last SHALL hold stable.
REQ-020 row_data SHALL always come from the snapshot, never live cells; cells changes after capture SHALL not affect the frame.
REQ-021 On the row N-1 handshake with no gen_valid in the same cycle, the FSM SHALL return to IDLE and row_valid SHALL go low next cycle.
REQ-022 On the row N-1 handshake with gen_valid in the same cycle, the new frame SHALL be captured (REQ-016 actions) and row 0 presented next cycle, with no idle bubble and no drop.
REQ-023 gen_valid in STREAM other than per REQ-022 SHALL be discarded: snapshot and pop_count unchanged, drop_pulse high the following cycle, drop_count incremented, saturating at 255.
REQ-024 row_ready while row_valid is low SHALL be ignored.
REQ-025 pop_count SHALL hold its value until the next capture; range 0..N*N inclusive without overflow.

Reset
REQ-026 rst high SHALL immediately force: state IDLE, row pointer 0, snapshot 0, row_valid 0, row_last 0, row_data 0, row_idx 0, pop_count 0, busy 0, drop_pulse 0, drop_count 0.
REQ-027 rst asserted mid-frame SHALL abandon the frame; after release, no row SHALL be emitted until a new gen_valid.
REQ-028 gen_valid in the first cycle after rst release SHALL be honoured normally.

Structure
REQ-029 Shared package life_pkg SHALL hold the state enum type (IDLE, STREAM) and the default grid size constant (8).
REQ-030 Popcount SHALL be a sub-module life_popcount (parameter W, input W bits, output $clog2(W+1) bits, purely combinational).
REQ-031 Target size 120-400 RTL lines; no memories, snapshot in flops.

Verification
REQ-032 N=8, cells=64'h4020E00000000000 (glider), gen_valid one cycle, row_ready=1 -> rows 0..7 = 0x40,0x20,0xE0,0x00 x5 on 8 consecutive cycles, row_last only on row 7, pop_count=5.
REQ-033 Same frame, row_ready low for 3 cycles during row 2 -> row 2 (0xE0, idx 2) held stable 3 cycles, stream then completes in order with no row lost or duplicated.
REQ-034 gen_valid pulsed at row 3 of a frame with cells=all-ones -> drop_pulse one cycle, drop_count=1, remaining rows still glider, pop_count stays 5.
REQ-035 gen_valid coincident with row 7 handshake, cells=all-ones -> next cycle row 0 = 0xFF, pop_count=64, no idle cycle, drop_count unchanged.
REQ-036 rst asserted during row 4 -> all outputs 0 asynchronously; after release, row_valid stays 0 until gen_valid, then fresh frame starts at row 0.
REQ-037 300 discarded gen_valid pulses during one held stream (row_ready=0) -> drop_count saturates at 255.
